spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI target (responder) endpoint, the far end of the board-level SPI master port.
//  Samples externally driven SCLK/MOSI/SS_n in the clk_clk domain and assembles
//  MOSI words for the fabric. Shifts fabric-supplied words out on MISO.
//  Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first, one word per DATA_W SCLK cycles.
// PARAMETERS
//  DATA_W       8      bits per SPI word
//  SYNC_STAGES  2      synchroniser flops on SCLK/MOSI/SS_n (>=2)
//  FILL         8'hFF  word shifted out on TX underrun (width DATA_W)
// PORTS
//  clk_clk               in   1       single system clock; all logic on rising edge
//  reset_reset           in   1       synchronous, active-high reset
//  spi_external_SCLK     in   1       SPI clock from master (async to clk_clk)
//  spi_external_MOSI     in   1       master-out data
//  spi_external_SS_n     in   1       active-low select
//  spi_external_MISO     out  1       target-out data
//  spi_external_MISO_oe  out  1       MISO tri-state enable (1 only while selected)
//  rx_data               out  DATA_W  last complete received word
//  rx_valid              out  1       1-cycle pulse: rx_data updated; no backpressure
//  tx_data               in   DATA_W  next word to transmit
//  tx_valid              in   1       tx_data offered
//  tx_ready              out  1       holding register empty; transfer on valid&ready
//  underrun              out  1       1-cycle pulse: FILL loaded because holding was empty
//  frame_abort           out  1       1-cycle pulse: SS_n rose with a partial word
//  busy                  out  1       1 while state==SHIFT
// BEHAVIOUR
//  Reset values: MISO=0, MISO_oe=0, rx_data=0, rx_valid=0, underrun=0, frame_abort=0,
//    busy=0, tx_ready=0 while reset_reset=1. Holding register empty; state=IDLE;
//    sync flops load SS_n=1, SCLK=0, MOSI=0.
//  Requires f(clk_clk) >= 4*f(SCLK). Slower clk_clk gives undefined results.
//  Sync: each input passes SYNC_STAGES flops. Edges on SCLK and SS_n come from the
//    last stage vs one extra delayed flop.
//  tx_ready = !hold_full && !reset_reset. Accept when tx_valid&&tx_ready. At most one word held.
//  FSM:
//    IDLE: MISO_oe=0. A falling edge of SS_n moves to SHIFT, bit_cnt=0, tx_shift loaded
//      from holding if full (hold emptied), else FILL with an underrun pulse.
//      MISO_oe=1 and MISO=tx_shift[MSB] from the next cycle.
//    SHIFT, SCLK rising edge: rx_shift={rx_shift[DATA_W-2:0],MOSI_s}; bit_cnt++.
//      On bit_cnt==DATA_W-1: rx_data<=completed word, rx_valid=1 next cycle, bit_cnt wraps to 0.
//    SHIFT, SCLK falling edge: if bit_cnt==0 (word boundary), reload tx_shift from
//      holding or FILL (with underrun pulse). Otherwise shift tx_shift left by 1.
//    SHIFT, SS_n rising edge: go to IDLE, MISO_oe=0. If bit_cnt!=0, partial rx bits are
//      dropped, frame_abort pulses, no rx_valid. A loaded but unsent tx word is lost.
//  Simultaneous events:
//    - Accept and load in the same cycle: the load sees the pre-accept state (FILL +
//      underrun). The accepted word stays in the holding register for the next word.
//    - SS_n rise and SCLK edge in the same cycle: SS_n wins and the SCLK edge is ignored.
//  Latency: rx_valid at the pins = SYNC_STAGES+2 clk_clk cycles after the DATA_W-th
//    SCLK rising edge.
//  Reset mid-frame: state forced to IDLE. A new frame starts only after SS_n is seen
//    high then falling; SCLK activity before that is ignored.
// STRUCTURE
//  Package spi_resp_pkg: state enum {IDLE, SHIFT}, DEFAULT_DATA_W, DEFAULT_FILL.
//  Sub-module spi_sync_edge (SYNC_STAGES sync + rise/fall pulses, reset value param).
//    Instantiated for SCLK and SS_n. MOSI uses the sync chain only.
//  Top holds FSM, bit counter ($clog2(DATA_W) bits), rx/tx shift registers, holding register.
// TESTING
//  1. Preload tx 8'hA5, master sends 8'h3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1;
//     rx_valid once with rx_data=8'h3C; tx_ready high again after SS_n falls.
//  2. No tx preload, 2-word frame -> MISO shows 8'hFF twice, underrun pulses twice,
//     rx_valid twice.
//  3. tx_valid held with 8'h11,8'h22,8'h33, 3-word frame -> MISO 11,22,33 in order;
//     tx_ready drops between accepts; no underrun.
//  4. SS_n deasserted after 5 SCLKs -> frame_abort=1 for 1 cycle, no rx_valid, MISO_oe=0;
//     next full frame receives correctly.
//  5. reset_reset asserted for 1 cycle mid-word, SCLK keeps toggling with SS_n low
//     -> no rx_valid until SS_n toggles high then low; all outputs at reset values.
//  6. Sweep SCLK at clk/4, clk/5, clk/16 with random data -> rx/tx scoreboard match;
//     rx_valid latency exactly SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/spi_resp_pkg.sv
// rtl/spi_resp_pkg.sv - shared types and defaults for the SPI responder
package spi_resp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         DEFAULT_DATA_W = 8;
  localparam logic [7:0] DEFAULT_FILL   = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - async input synchroniser with rise/fall pulse detection
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;
  logic [STAGES:0]   primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= {STAGES{RESET_VAL}};
      dly    <= RESET_VAL;
      primed <= '0;
    end else begin
      chain  <= {chain[STAGES-2:0], din};
      dly    <= chain[STAGES-1];
      primed <= {primed[STAGES-1:0], 1'b1};
    end
  end

  // Edges only count once the chain holds real samples, so the reset value
  // can never be mistaken for a transition on the pin.
  assign rise = primed[STAGES] &&  chain[STAGES-1] && !dly;
  assign fall = primed[STAGES] && !chain[STAGES-1] &&  dly;

endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode 0 target: MOSI word assembly, MISO word shifting
module spi_slave_responder
  import spi_resp_pkg::*;
#(
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL        = DATA_W'(DEFAULT_FILL)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_external_SCLK,
  input  logic              spi_external_MOSI,
  input  logic              spi_external_SS_n,
  output logic              spi_external_MISO,
  output logic              spi_external_MISO_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nx;
  logic [DATA_W-2:0]      rx_shift, rx_shift_nx;
  logic [DATA_W-1:0]      tx_shift, tx_shift_nx;
  logic [DATA_W-1:0]      hold, hold_nx;
  logic                   hold_full, hold_full_nx;
  logic [DATA_W-1:0]      rx_data_nx, rx_word;
  logic                   rx_pend, rx_pend_nx;
  logic                   underrun_nx, frame_abort_nx;
  logic                   load, accept, active;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .din  (spi_external_SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .din  (spi_external_SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign accept = tx_valid && tx_ready;

  always_comb begin
    state_nx       = state;
    bit_cnt_nx     = bit_cnt;
    rx_shift_nx    = rx_shift;
    tx_shift_nx    = tx_shift;
    rx_data_nx     = rx_data;
    rx_pend_nx     = 1'b0;
    underrun_nx    = 1'b0;
    frame_abort_nx = 1'b0;
    hold_nx        = hold;
    hold_full_nx   = hold_full;
    load           = 1'b0;
    rx_word        = {rx_shift, mosi_s};

    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        // Deselect takes priority over any SCLK edge seen in the same cycle.
        if (ss_rise) begin
          state_nx       = IDLE;
          frame_abort_nx = (bit_cnt != '0);
        end else if (sclk_rise) begin
          rx_shift_nx = rx_word[DATA_W-2:0];
          if (bit_cnt == LAST) begin
            bit_cnt_nx = '0;
            rx_data_nx = rx_word;
            rx_pend_nx = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt == '0) load = 1'b1;
          else               tx_shift_nx = {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
      default: state_nx = IDLE;
    endcase

    // A load sees the holding register as it was before this cycle's accept.
    if (load) begin
      if (hold_full) begin
        tx_shift_nx  = hold;
        hold_full_nx = 1'b0;
      end else begin
        tx_shift_nx = FILL;
        underrun_nx = 1'b1;
      end
    end
    if (accept) begin
      hold_nx      = tx_data;
      hold_full_nx = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      rx_data     <= '0;
      rx_pend     <= 1'b0;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      frame_abort <= 1'b0;
      mosi_sync   <= '0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      rx_shift    <= rx_shift_nx;
      tx_shift    <= tx_shift_nx;
      hold        <= hold_nx;
      hold_full   <= hold_full_nx;
      rx_data     <= rx_data_nx;
      rx_pend     <= rx_pend_nx;
      rx_valid    <= rx_pend;
      underrun    <= underrun_nx;
      frame_abort <= frame_abort_nx;
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_external_MOSI};
    end
  end

  assign active               = (state == SHIFT) && !reset_reset;
  assign spi_external_MISO_oe = active;
  assign spi_external_MISO    = active && tx_shift[DATA_W-1];
  assign busy                 = active;
  assign tx_ready             = !hold_full && !reset_reset;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - randomized bench for spi_slave_responder against a queue model
module tb_spi_slave_responder;

  localparam int         DATA_W = 8;
  localparam int         SYNC   = 2;
  localparam logic [7:0] FILL   = 8'hFF;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, underrun, frame_abort, busy;

  spi_slave_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC), .FILL(FILL)) dut (
    .clk_clk              (clk_clk),
    .reset_reset          (reset_reset),
    .spi_external_SCLK    (sclk),
    .spi_external_MOSI    (mosi),
    .spi_external_SS_n    (ss_n),
    .spi_external_MISO    (miso),
    .spi_external_MISO_oe (miso_oe),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .underrun             (underrun),
    .frame_abort          (frame_abort),
    .busy                 (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model state: words waiting in the holding register, words loaded for MISO,
  // words the master has fully clocked out on MOSI, and scheduled pin-event effects.
  logic [7:0] hold_q[$];
  logic [7:0] miso_exp[$];
  logic [7:0] rx_exp[$];
  int         rx_t[$];
  bit         load_at[int];
  bit         fa_at[int];
  logic [7:0] seq_q[$];
  logic [7:0] got_w[$];
  int         tx_mode = 0;
  bit         mon_on = 0;
  bit         acc_pend = 0;
  logic [7:0] acc_data;
  int         under_cnt = 0, fa_cnt = 0, rx_cnt = 0, acc_cnt = 0, ready_drops = 0;
  logic       ready_prev = 1'b0;

  always @(negedge clk_clk) begin
    if (!mon_on || reset_reset) begin
      tx_valid = 1'b0;
      acc_pend = 0;
    end else begin
      if (underrun) under_cnt++;
      if (frame_abort) fa_cnt++;
      if (load_at.exists(cyc)) begin
        load_at.delete(cyc);
        if (hold_q.size() > 0) begin
          check("underrun_on_full_load", underrun, 0);
          miso_exp.push_back(hold_q.pop_front());
        end else begin
          check("underrun_on_empty_load", underrun, 1);
          miso_exp.push_back(FILL);
        end
      end else begin
        check("underrun_no_load", underrun, 0);
      end
      check("frame_abort", frame_abort, fa_at.exists(cyc));
      if (fa_at.exists(cyc)) fa_at.delete(cyc);
      if (rx_valid) begin
        rx_cnt++;
        if (rx_exp.size() == 0) begin
          check("rx_valid_unexpected", 1, 0);
        end else begin
          check("rx_data", rx_data, rx_exp.pop_front());
          check("rx_latency", cyc - rx_t.pop_front(), SYNC + 2);
        end
      end else if (rx_t.size() > 0 && cyc - rx_t[0] > SYNC + 2) begin
        check("rx_valid_missing", 0, 1);
        void'(rx_t.pop_front());
        void'(rx_exp.pop_front());
      end
      if (acc_pend) begin
        hold_q.push_back(acc_data);
        acc_cnt++;
      end
      check("tx_ready", tx_ready, hold_q.size() == 0);
      if (ready_prev && !tx_ready) ready_drops++;
      ready_prev = tx_ready;
      acc_pend = 0;
      case (tx_mode)
        1: begin
          tx_valid = ($urandom_range(0, 3) == 0);
          tx_data  = 8'($urandom);
        end
        2: begin
          tx_valid = (seq_q.size() > 0);
          if (seq_q.size() > 0) tx_data = seq_q[0];
        end
        default: tx_valid = 1'b0;
      endcase
      if (tx_valid && tx_ready) begin
        acc_pend = 1;
        acc_data = tx_data;
        if (tx_mode == 2) void'(seq_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_clk);
      #1;
    end
  endtask

  // Master: drives MOSI per bit, samples MISO at the end of the high phase.
  // The final SCLK fall coincides with the SS_n rise, so no reload occurs there.
  task automatic frame(input int nw, input int per, input int abort_after);
    logic [7:0] mw, sw;
    int total, b;
    total = (abort_after != 0) ? abort_after : nw * DATA_W;
    got_w.delete();
    mw = 8'h00;
    sw = 8'h00;
    tick(1);
    ss_n = 1'b0;
    load_at[cyc + SYNC + 1] = 1;
    tick(6);
    for (int i = 0; i < total; i++) begin
      b = DATA_W - 1 - (i % DATA_W);
      if (b == DATA_W - 1) mw = 8'($urandom);
      mosi = mw[b];
      tick(per - per / 2);
      sclk = 1'b1;
      if (b == 0) begin
        rx_exp.push_back(mw);
        rx_t.push_back(cyc);
      end
      tick(per / 2);
      check("miso_oe_active", miso_oe, 1);
      sw[b] = miso;
      if (b == 0) begin
        got_w.push_back(sw);
        if (miso_exp.size() == 0) check("miso_word_missing", 0, 1);
        else check("miso_word", sw, miso_exp.pop_front());
      end
      sclk = 1'b0;
      if (i == total - 1) begin
        ss_n = 1'b1;
        if (abort_after != 0) fa_at[cyc + SYNC + 1] = 1;
      end else if (b == 0) begin
        load_at[cyc + SYNC + 1] = 1;
      end
    end
    tick(8);
    miso_exp.delete();
    check("miso_oe_idle", miso_oe, 0);
    check("miso_idle", miso, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic wait_seq_drained();
    for (int k = 0; k < 100 && seq_q.size() > 0; k++) tick(1);
    tick(3);
    check("seq_drained", seq_q.size(), 0);
  endtask

  int u0, r0, f0, a0, d0;
  int pers[3] = '{4, 5, 16};

  initial begin
    tick(4);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_abort", frame_abort, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);
    reset_reset = 1'b0;
    mon_on = 1;
    tick(8);

    // Preloaded A5 out, 3C in.
    r0 = rx_cnt;
    seq_q.push_back(8'hA5);
    tx_mode = 2;
    wait_seq_drained();
    tx_mode = 0;
    check("t1_hold_full", tx_ready, 0);
    frame(1, 8, 0);
    check("t1_miso_a5", got_w.size() > 0 ? got_w[0] : 8'hxx, 8'hA5);
    check("t1_rx_count", rx_cnt - r0, 1);
    check("t1_tx_ready_again", tx_ready, 1);

    // Empty holding register: two FILL words.
    u0 = under_cnt;
    r0 = rx_cnt;
    frame(2, 8, 0);
    check("t2_word0_fill", got_w.size() > 0 ? got_w[0] : 8'hxx, FILL);
    check("t2_word1_fill", got_w.size() > 1 ? got_w[1] : 8'hxx, FILL);
    check("t2_underruns", under_cnt - u0, 2);
    check("t2_rx_count", rx_cnt - r0, 2);

    // Streamed words with tx_valid held.
    u0 = under_cnt;
    a0 = acc_cnt;
    d0 = ready_drops;
    seq_q.push_back(8'h11);
    seq_q.push_back(8'h22);
    seq_q.push_back(8'h33);
    tx_mode = 2;
    tick(6);
    frame(3, 8, 0);
    tx_mode = 0;
    check("t3_word0", got_w.size() > 0 ? got_w[0] : 8'hxx, 8'h11);
    check("t3_word1", got_w.size() > 1 ? got_w[1] : 8'hxx, 8'h22);
    check("t3_word2", got_w.size() > 2 ? got_w[2] : 8'hxx, 8'h33);
    check("t3_no_underrun", under_cnt - u0, 0);
    check("t3_accepts", acc_cnt - a0, 3);
    check("t3_ready_drops", ready_drops - d0, 3);

    // Abort after 5 SCLKs, then a clean frame.
    f0 = fa_cnt;
    r0 = rx_cnt;
    frame(1, 8, 5);
    check("t4_abort_count", fa_cnt - f0, 1);
    check("t4_no_rx", rx_cnt - r0, 0);
    frame(1, 8, 0);
    check("t4_rx_after_abort", rx_cnt - r0, 1);

    // Reset mid-word while SCLK keeps toggling with SS_n low.
    r0 = rx_cnt;
    f0 = fa_cnt;
    ss_n = 1'b0;
    load_at[cyc + SYNC + 1] = 1;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom);
      tick(2); sclk = 1'b1; tick(2); sclk = 1'b0;
    end
    reset_reset = 1'b1;
    hold_q.delete();
    tick(1);
    check("t5_rst_miso", miso, 0);
    check("t5_rst_miso_oe", miso_oe, 0);
    check("t5_rst_rx_valid", rx_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tx_ready", tx_ready, 0);
    check("t5_rst_underrun", underrun, 0);
    reset_reset = 1'b0;
    miso_exp.delete();
    for (int i = 0; i < 12; i++) begin
      mosi = 1'($urandom);
      tick(2); sclk = 1'b1; tick(2); sclk = 1'b0;
    end
    check("t5_no_rx_while_stale", rx_cnt - r0, 0);
    check("t5_still_idle", busy, 0);
    ss_n = 1'b1;
    tick(6);
    check("t5_no_abort", fa_cnt - f0, 0);
    frame(1, 8, 0);
    check("t5_rx_after_reselect", rx_cnt - r0, 1);

    // Random sweep across SCLK ratios.
    tx_mode = 1;
    foreach (pers[p]) begin
      for (int rep = 0; rep < 3; rep++) frame($urandom_range(1, 3), pers[p], 0);
    end
    tx_mode = 0;
    tick(10);
    check("rx_all_delivered", rx_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
